// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI3 INCR burst master with a simple command/stream front end.
// Rejects misaligned or 4 KB-crossing commands and reports completion status with a one-cycle done pulse.
module axi_burst_master #(
   parameter logic [11:0] C_ID = 12'h000
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_wr,
   input  logic [31:0] i_cmd_addr,
   input  logic [3:0]  i_cmd_len,
   input  logic        i_wvalid,
   output logic        o_wready,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic        o_rvalid,
   input  logic        i_rready,
   output logic [31:0] o_rdata,
   output logic        o_rlast,
   output logic        o_done,
   output logic        o_err,
   output logic [11:0] M_AXI_AWID,
   output logic [31:0] M_AXI_AWADDR,
   output logic [3:0]  M_AXI_AWLEN,
   output logic [1:0]  M_AXI_AWSIZE,
   output logic [1:0]  M_AXI_AWBURST,
   output logic [1:0]  M_AXI_AWLOCK,
   output logic [3:0]  M_AXI_AWCACHE,
   output logic [2:0]  M_AXI_AWPROT,
   output logic [3:0]  M_AXI_AWQOS,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [11:0] M_AXI_WID,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WLAST,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [11:0] M_AXI_BID,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [11:0] M_AXI_ARID,
   output logic [31:0] M_AXI_ARADDR,
   output logic [3:0]  M_AXI_ARLEN,
   output logic [1:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic [1:0]  M_AXI_ARLOCK,
   output logic [3:0]  M_AXI_ARCACHE,
   output logic [2:0]  M_AXI_ARPROT,
   output logic [3:0]  M_AXI_ARQOS,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [11:0] M_AXI_RID,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RLAST,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);
   typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA, REJECT} state_t;
   state_t state, nxt;
   logic [31:0] addr;
   logic [3:0]  len, cnt;
   logic [12:0] end_addr;
   logic aw_done, w_done, err;
   logic acc, bad, w_act, rd, aw_hs, w_hs, w_last, r_hs, r_end, r_err, unused;

   assign unused = ^{M_AXI_BID, M_AXI_RID, M_AXI_BRESP[0], M_AXI_RRESP[0]};

   assign o_cmd_ready = state == IDLE && !M_AXI_ARESET;
   assign acc = i_cmd_valid && o_cmd_ready;
   // byte offset within the 4 KB page one past the final beat
   assign end_addr = {1'b0, i_cmd_addr[11:0]} + {7'd0, i_cmd_len, 2'b00} + 13'd4;
   assign bad = i_cmd_addr[1:0] != 2'b00 || end_addr > 13'd4096;

   assign M_AXI_AWID = C_ID;
   assign M_AXI_WID = C_ID;
   assign M_AXI_ARID = C_ID;
   assign {M_AXI_AWADDR, M_AXI_ARADDR} = {addr, addr};
   assign {M_AXI_AWLEN, M_AXI_ARLEN} = {len, len};
   assign {M_AXI_AWSIZE, M_AXI_ARSIZE} = {2'b10, 2'b10};
   assign {M_AXI_AWBURST, M_AXI_ARBURST} = {2'b01, 2'b01};
   assign {M_AXI_AWLOCK, M_AXI_ARLOCK} = 4'b0000;
   assign {M_AXI_AWCACHE, M_AXI_ARCACHE} = {4'b0011, 4'b0011};
   assign {M_AXI_AWPROT, M_AXI_ARPROT} = 6'b000000;
   assign {M_AXI_AWQOS, M_AXI_ARQOS} = 8'h00;

   assign w_act = state == WR && !w_done;
   assign M_AXI_AWVALID = state == WR && !aw_done;
   assign M_AXI_WVALID = w_act && i_wvalid;
   assign o_wready = w_act && M_AXI_WREADY;
   assign M_AXI_WLAST = w_act && cnt == 4'd0;
   assign M_AXI_WDATA = i_wdata;
   assign M_AXI_WSTRB = i_wstrb;
   assign M_AXI_BREADY = state == WRESP;
   assign M_AXI_ARVALID = state == RD_ADDR;

   assign rd = state == RD_DATA;
   assign M_AXI_RREADY = rd && i_rready;
   assign o_rvalid = rd && M_AXI_RVALID;
   assign o_rdata = M_AXI_RDATA;
   assign o_rlast = rd && M_AXI_RLAST;

   assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
   assign w_last = w_hs && cnt == 4'd0;
   assign r_hs = o_rvalid && i_rready;
   assign r_end = r_hs && (M_AXI_RLAST || cnt == 4'd0);
   // a burst is malformed whenever RLAST disagrees with the beat count
   assign r_err = err || M_AXI_RRESP[1] || (M_AXI_RLAST != (cnt == 4'd0));

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
      if (M_AXI_ARESET) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !acc ? IDLE : bad ? REJECT : i_cmd_wr ? WR : RD_ADDR;
         WR:      nxt = (aw_done || aw_hs) && (w_done || w_last) ? WRESP : WR;
         WRESP:   nxt = M_AXI_BVALID ? IDLE : WRESP;
         RD_ADDR: nxt = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
         RD_DATA: nxt = r_end ? IDLE : RD_DATA;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
      if (M_AXI_ARESET) begin
         addr <= '0;
         len <= '0;
         cnt <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
         err <= 1'b0;
         o_done <= 1'b0;
         o_err <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err <= 1'b0;
         if (acc) begin
            addr <= i_cmd_addr;
            len <= i_cmd_len;
            cnt <= i_cmd_len;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            err <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs) begin
            if (cnt == 4'd0) w_done <= 1'b1;
            else cnt <= cnt - 4'd1;
         end
         if (r_hs) begin
            cnt <= cnt - 4'd1;
            err <= r_err;
         end
         if (state == WRESP && M_AXI_BVALID) {o_done, o_err} <= {1'b1, M_AXI_BRESP[1]};
         if (r_end) {o_done, o_err} <= {1'b1, r_err};
         if (state == REJECT) {o_done, o_err} <= 2'b11;
      end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bench with an AXI slave emulation and a per-cycle protocol/data model checker.
module tb_axi_burst_master;
   localparam logic [11:0] ID = 12'hA5C;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, i_cmd_valid, o_cmd_ready, i_cmd_wr, i_wvalid, o_wready, o_rvalid, i_rready, o_rlast, o_done, o_err;
   logic [31:0] i_cmd_addr, i_wdata, o_rdata;
   logic [3:0] i_cmd_len, i_wstrb;
   logic [11:0] awid, wid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0] awlen, arlen, awcache, arcache, awqos, arqos, wstrb;
   logic [1:0] awsize, arsize, awburst, arburst, awlock, arlock, bresp, rresp;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready, rlast, rvalid, rready;

   axi_burst_master #(.C_ID(ID)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
      .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rlast(o_rlast),
      .o_done(o_done), .o_err(o_err),
      .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
      .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WID(wid), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
      .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   int total = 0, bad = 0, done_cnt = 0, wk = 0, rk = 0;
   logic [31:0] wdat [0:16];
   logic [3:0] wsb [0:16];
   logic [31:0] exp_addr = '0;
   logic [3:0] exp_len = '0;
   logic exp_wr = 1'b0, exp_rej = 1'b0, exp_err = 1'b0, exp_nolast = 1'b0;
   int exp_early = -1;
   logic last_err, last_seen;
   int last_cyc, last_aw, last_beats, last_lb;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] rmem(input logic [31:0] a, input int k);
      return (a + 32'(4 * k)) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic rl(input int k);
      return exp_nolast ? 1'b0 : exp_early >= 0 ? k == exp_early : k == int'(exp_len);
   endfunction

   // a burst is refused if misaligned or if its bytes run past the end of the 4 KB page
   function automatic logic rejects(input logic [31:0] a, input logic [3:0] l);
      return (a % 4) != 0 || int'(a % 4096) + 4 * (int'(l) + 1) > 4096;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_outs", {awvalid, wvalid, bready, arvalid, rready, o_wready, o_rvalid, o_cmd_ready,
                          o_done, o_err, awaddr, awlen, araddr, arlen}, '0);
         wk = 0;
         rk = 0;
      end else begin
         chk("sideband", {awid, awsize, awburst, awlock, awcache, awprot, awqos, wid,
                          arid, arsize, arburst, arlock, arcache, arprot, arqos},
             {ID, 2'b10, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, ID,
              ID, 2'b10, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000});
         if (i_cmd_valid && o_cmd_ready) begin
            wk = 0;
            rk = 0;
         end
         if (awvalid) chk("aw", {awaddr, awlen, 1'b1}, {exp_addr, exp_len, exp_wr && !exp_rej});
         if (arvalid) chk("ar", {araddr, arlen, 1'b1}, {exp_addr, exp_len, !exp_wr && !exp_rej});
         if (wvalid) begin
            chk("wbeat", {wdata, wstrb, wlast, o_wready, 1'b1},
                {wdat[wk > 16 ? 16 : wk], wsb[wk > 16 ? 16 : wk], wk == int'(exp_len), wready, wk <= int'(exp_len)});
            if (wready) wk++;
         end
         if (bready) chk("bready_beats", wk, int'(exp_len) + 1);
         if (o_rvalid) begin
            chk("rbeat", {o_rdata, o_rlast, rready}, {rmem(exp_addr, rk), rl(rk), i_rready});
            if (i_rready) rk++;
         end
         if (o_done) begin
            chk("done_err", o_err, exp_err);
            done_cnt++;
         end
      end
   end

   task automatic idle_inputs();
      {i_cmd_valid, i_cmd_wr, i_wvalid, i_rready, awready, wready, bvalid, arready, rvalid, rlast} = '0;
      {i_cmd_addr, i_cmd_len, i_wdata, i_wstrb, bresp, rresp, rdata} = '0;
      bid = 12'h111;
      rid = 12'h222;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l);
      @(posedge clk); #1;
      {i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_len} = {1'b1, wr, a, l};
      #1 chk("cmd_ready", o_cmd_ready, 1'b1);
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic finish_txn(input int d0);
      @(posedge clk); #1;
      chk("done_pulse", {o_done, o_cmd_ready}, 2'b01);
      chk("one_done", done_cnt, d0 + 1);
   endtask

   task automatic run_write(input logic [31:0] a, input logic [3:0] l, input int awd, input int wgap,
                            input logic [1:0] br, input int rst_at);
      int wi = 0, awc = 0, cyc = 1, d0 = done_cnt, at_aw = -1;
      logic aw_ok = 1'b0, bdone = 1'b0, fin = 1'b0, seen = 1'b0, aborted = 1'b0;
      {exp_wr, exp_addr, exp_len, exp_early, exp_nolast} = {1'b1, a, l, -32'sd1, 1'b0};
      exp_rej = rejects(a, l);
      exp_err = exp_rej | br[1];
      for (int k = 0; k <= 16; k++) begin
         wdat[k] = 32'(k + 1) + {a[15:0], 16'h0};
         wsb[k] = 4'(15 - k);
      end
      issue(1'b1, a, l);
      while (!fin) begin
         if (rst_at >= 0 && wi == rst_at) begin
            rst = 1'b1;
            #1 chk("abort_valids", {awvalid, wvalid, bready, arvalid, rready, o_wready, o_cmd_ready}, '0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            idle_inputs();
            #1 chk("release_ready", o_cmd_ready, 1'b1);
            repeat (3) @(posedge clk);
            #1 chk("abort_no_done", done_cnt, d0);
            fin = 1'b1;
            aborted = 1'b1;
         end else begin
            i_wvalid = wi <= int'(l) && (wgap == 0 || cyc % 2 == 0);
            i_wdata = wi <= int'(l) ? wdat[wi] : '0;
            i_wstrb = wi <= int'(l) ? wsb[wi] : '0;
            wready = 1'b1;
            awready = awc >= awd;
            bvalid = aw_ok && wi > int'(l) && !bdone;
            bresp = br;
            #1;
            seen |= awvalid | wvalid;
            if (awvalid) begin
               if (awready) {aw_ok, at_aw} = {1'b1, wi};
               else awc++;
            end
            if (wvalid && wready) wi++;
            if (bvalid && bready) bdone = 1'b1;
            if (o_done) begin
               fin = 1'b1;
               last_err = o_err;
            end else if (cyc >= 300) begin
               chk("write_timeout", o_done, 1'b1);
               fin = 1'b1;
            end else begin
               @(posedge clk); #1;
               cyc++;
            end
         end
      end
      {last_cyc, last_aw, last_seen} = {cyc, at_aw, seen};
      if (!aborted) begin
         idle_inputs();
         finish_txn(d0);
      end
   endtask

   task automatic run_read(input logic [31:0] a, input logic [3:0] l, input int ard, input logic alt,
                           input int early, input logic nolast, input logic [15:0] emask);
      int rb = 0, arc = 0, cyc = 1, d0 = done_cnt, lb = -1;
      int nb = early >= 0 ? early + 1 : int'(l) + 1;
      logic ar_ok = 1'b0, fin = 1'b0, e = 1'b0;
      {exp_wr, exp_addr, exp_len, exp_early, exp_nolast} = {1'b0, a, l, early, nolast};
      exp_rej = rejects(a, l);
      for (int k = 0; k < nb; k++) e |= emask[k];
      exp_err = exp_rej | e | (early >= 0 && early != int'(l)) | nolast;
      issue(1'b0, a, l);
      while (!fin) begin
         i_rready = alt ? cyc % 2 == 1 : 1'b1;
         arready = arc >= ard;
         rvalid = ar_ok && rb < nb;
         rdata = rmem(a, rb);
         rresp = {rb < 16 ? emask[rb] : 1'b0, 1'b0};
         rlast = rl(rb);
         #1;
         if (arvalid) begin
            if (arready) ar_ok = 1'b1;
            else arc++;
         end
         if (o_rvalid && i_rready) begin
            if (o_rlast) lb = rb;
            rb++;
         end
         if (o_done) begin
            fin = 1'b1;
            last_err = o_err;
         end else if (cyc >= 300) begin
            chk("read_timeout", o_done, 1'b1);
            fin = 1'b1;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      {last_cyc, last_beats, last_lb} = {cyc, rb, lb};
      idle_inputs();
      finish_txn(d0);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 chk("reset_cmd_ready", o_cmd_ready, 1'b0);
      rst = 1'b0;
      #1 chk("post_reset_ready", o_cmd_ready, 1'b1);

      run_write(32'h4000_0000, 4'd3, 5, 0, 2'b00, -1);
      chk("w0_beats_before_aw", last_aw, 4);
      chk("w0_done_cycle", last_cyc, 8);
      chk("w0_err", last_err, 1'b0);

      run_read(32'h4000_0100, 4'd15, 2, 1'b1, -1, 1'b0, 16'h0000);
      chk("r16_beats", last_beats, 16);
      chk("r16_rlast_beat", last_lb, 15);
      chk("r16_err", last_err, 1'b0);

      run_write(32'h4000_0FF8, 4'd3, 0, 0, 2'b00, -1);
      chk("rej_done_cycle", last_cyc, 2);
      chk("rej_err", last_err, 1'b1);
      chk("rej_no_valid", last_seen, 1'b0);

      run_read(32'h4000_0200, 4'd1, 0, 1'b0, -1, 1'b0, 16'h0001);
      chk("rresp_beats", last_beats, 2);
      chk("rresp_err", last_err, 1'b1);

      run_read(32'h4000_0300, 4'd3, 1, 1'b0, 2, 1'b0, 16'h0000);
      chk("early_last_beats", last_beats, 3);
      chk("early_last_err", last_err, 1'b1);

      run_write(32'h4000_0400, 4'd3, 0, 0, 2'b00, 2);
      run_write(32'h4000_0500, 4'd0, 0, 0, 2'b00, -1);
      chk("after_abort_err", last_err, 1'b0);

      run_write(32'h4000_0600, 4'd2, 0, 1, 2'b10, -1);
      chk("bresp_slverr", last_err, 1'b1);
      run_write(32'h4000_0700, 4'd1, 2, 1, 2'b01, -1);
      chk("bresp_exokay_ok", last_err, 1'b0);

      run_read(32'h0000_0FF0, 4'd3, 0, 1'b0, -1, 1'b0, 16'h0000);
      chk("page_fit_beats", last_beats, 4);
      chk("page_fit_err", last_err, 1'b0);

      run_read(32'h4000_0002, 4'd0, 0, 1'b0, -1, 1'b0, 16'h0000);
      chk("misaligned_cycle", last_cyc, 2);
      chk("misaligned_err", last_err, 1'b1);

      run_read(32'h4000_0800, 4'd2, 0, 1'b1, -1, 1'b1, 16'h0000);
      chk("missing_last_beats", last_beats, 3);
      chk("missing_last_err", last_err, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter C_ID, default 12'h000, the ID driven on AWID, WID and ARID.
REQ-002 SHALL have port M_AXI_ACLK, in, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port M_AXI_ARESET, in, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports i_cmd_valid in 1 and o_cmd_ready out 1: command handshake.
REQ-005 SHALL have ports i_cmd_wr in 1 (1 = write, 0 = read), i_cmd_addr in 32 and i_cmd_len in 4 (beats-1).
REQ-006 SHALL have ports i_wvalid in 1, o_wready out 1, i_wdata in 32 and i_wstrb in 4: write-data stream.
REQ-007 SHALL have ports o_rvalid out 1, i_rready in 1, o_rdata out 32 and o_rlast out 1: read-data stream.
REQ-008 SHALL have ports o_done out 1 (one-cycle completion pulse) and o_err out 1 (status, valid with o_done).
REQ-009 SHALL have AXI3 write-address ports M_AXI_AWID 12, AWADDR 32, AWLEN 4, AWSIZE 2, AWBURST 2, AWLOCK 2, AWCACHE 4, AWPROT 3, AWQOS 4 and AWVALID 1 as outputs, and M_AXI_AWREADY as input.
REQ-010 SHALL have write-data ports M_AXI_WID 12, WDATA 32, WSTRB 4, WLAST 1 and WVALID 1 as outputs, and M_AXI_WREADY as input.
REQ-011 SHALL have write-response ports M_AXI_BID 12, BRESP 2 and BVALID 1 as inputs, and M_AXI_BREADY as output.
REQ-012 SHALL have M_AXI_AR* read-address ports with the same names-pattern and widths as REQ-009 as outputs, and M_AXI_ARREADY as input.
REQ-013 SHALL have read-data ports M_AXI_RID 12, RDATA 32, RRESP 2, RLAST 1 and RVALID 1 as inputs, and M_AXI_RREADY as output.

Function
REQ-014 SHALL implement FSM states IDLE, WR, WRESP, RD_ADDR, RD_DATA and REJECT.
REQ-015 SHALL drive o_cmd_ready = (state==IDLE) && !reset, and SHALL latch addr/len/wr on the i_cmd_valid && o_cmd_ready edge.
REQ-016 SHALL enter REJECT at accept when addr[1:0]!=0 or addr[11:0]+4*(len+1)>4096 (4 KB crossing); REJECT asserts no AXI VALID and returns to IDLE next edge.
REQ-017 SHALL drive fixed sideband values: SIZE=2'b10, BURST=2'b01 (INCR), LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, all IDs=C_ID; ADDR/LEN carry the latched values and are stable while VALID is high.
REQ-018 In WR, SHALL raise AWVALID in the cycle after accept and hold it until the AWREADY handshake; W beats may precede, coincide with, or follow the AW handshake.
REQ-019 In WR while beats remain, SHALL drive WVALID=i_wvalid and o_wready=WREADY, with WDATA/WSTRB combinational from i_wdata/i_wstrb.
REQ-020 SHALL decrement a 4-bit beat counter per W handshake, assert WLAST when counter==0, and drive WVALID=0 and o_wready=0 after the last beat.
REQ-021 SHALL go WR->WRESP once both the AW handshake and the last W handshake are done (same cycle allowed), with BREADY=1 only in WRESP.
REQ-022 In WRESP, SHALL terminate on the B handshake with err=BRESP[1].
REQ-023 In RD_ADDR, SHALL hold ARVALID until ARREADY, then go to RD_DATA.
REQ-024 In RD_DATA, SHALL pass through combinationally RREADY=i_rready, o_rvalid=RVALID, o_rdata=RDATA and o_rlast=RLAST, decrementing the counter per R handshake.
REQ-025 For reads, err SHALL be the sticky OR of RRESP[1] over the burst, also set by RLAST on a beat with counter!=0 or by RLAST=0 on the counter==0 beat; the burst ends at whichever comes first.
REQ-026 o_done SHALL be registered, high exactly one cycle after the terminating B/R handshake or the REJECT cycle, with o_err valid that cycle (1 for REJECT) and 0 otherwise; FSM is IDLE in that cycle.
REQ-027 SHALL allow exactly one outstanding transaction; BID/RID are not checked.

Reset
REQ-028 While M_AXI_ARESET is high: state=IDLE, counter=0, err=0, all AXI VALID/READY outputs 0, o_cmd_ready=0, o_done=0, o_err=0, latched ADDR/LEN=0.
REQ-029 Reset mid-burst SHALL abort immediately with no o_done; the first cycle after release is IDLE with o_cmd_ready=1.

Verification
REQ-030 Write 0x4000_0000, len 3, data 1..4, AWREADY delayed 5 cycles, WREADY=1 -> 4 W beats complete before AW handshake, WLAST on 4th, BRESP=00 -> o_done=1, o_err=0.
REQ-031 Read 0x4000_0100, len 15, i_rready alternating 1/0 -> 16 beats in order, o_rlast on 16th, single o_done, o_err=0.
REQ-032 Write 0x4000_0FF8, len 3 -> REJECT; o_done=1, o_err=1 two cycles after accept; AWVALID/WVALID never 1.
REQ-033 Read len 1 with RRESP=2'b10 on beat 0 and 2'b00 on beat 1 -> o_done with o_err=1.
REQ-034 Read len 3, slave asserts RLAST on beat 2 -> burst ends after beat 2, o_err=1.
REQ-035 Reset asserted during beat 2 of a 4-beat write -> all VALIDs 0 at once, no o_done; after release a len-0 write completes with o_err=0.
